// File: rtl/led_sbox_serial_ctrl.sv
// Nibble-serial sequencer feeding a 3-share masked LED S-box pipeline and reassembling its output.
// Optional SBOX_PRECHARGE_EN inserts an all-zero slot after every issued nibble.
module led_sbox_serial_ctrl #(
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] st_in1,
  input  logic [63:0] st_in2,
  input  logic [63:0] st_in3,
  output logic [3:0]  sb_in1,
  output logic [3:0]  sb_in2,
  output logic [3:0]  sb_in3,
  output logic        rnd_en,
  input  logic [3:0]  sb_out1,
  input  logic [3:0]  sb_out2,
  input  logic [3:0]  sb_out3,
  output logic [63:0] st_out1,
  output logic [63:0] st_out2,
  output logic [63:0] st_out3,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [63:0]         r_buf1, r_buf2, r_buf3;
  logic [3:0]          r_issue_cnt;
  logic [3:0]          r_cap_cnt;
  logic [SBOX_LAT-1:0] r_vpipe;
  logic [3:0]          r_sb_in1, r_sb_in2, r_sb_in3;
  logic                r_rnd_en;
  logic [63:0]         r_st_out1, r_st_out2, r_st_out3;
  logic                w_load_first;
  logic                w_load_next;
  logic                w_rnd_nxt;
  logic                w_cap;
  logic                w_last_cap;

  assign w_cap      = r_vpipe[SBOX_LAT-1];
  assign w_last_cap = w_cap && (r_cap_cnt == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // The last capture can land in the final FEED slot when SBOX_LAT=1, so FEED may exit straight to DONE.
  always_comb begin
    w_next       = r_state;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load_first = 1'b1;
          w_next       = FEED;
        end
      end
      FEED: begin
`ifdef SBOX_PRECHARGE_EN
        w_load_next = !r_rnd_en;
`else
        w_load_next = (r_issue_cnt != 4'hF);
`endif
        if (r_rnd_en && (r_issue_cnt == 4'hF))
          w_next = w_last_cap ? DONE : DRAIN;
      end
      DRAIN: begin
        if (w_last_cap) w_next = DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_rnd_nxt = w_load_first || w_load_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf1      <= '0;
      r_buf2      <= '0;
      r_buf3      <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_vpipe     <= '0;
      r_sb_in1    <= '0;
      r_sb_in2    <= '0;
      r_sb_in3    <= '0;
      r_rnd_en    <= 1'b0;
      r_st_out1   <= '0;
      r_st_out2   <= '0;
      r_st_out3   <= '0;
    end else begin
      r_rnd_en   <= w_rnd_nxt;
      r_vpipe[0] <= w_rnd_nxt;
      for (int unsigned k = 1; k < SBOX_LAT; k++) r_vpipe[k] <= r_vpipe[k-1];

      if (w_load_first) begin
        r_sb_in1    <= st_in1[3:0];
        r_sb_in2    <= st_in2[3:0];
        r_sb_in3    <= st_in3[3:0];
        r_buf1      <= {4'h0, st_in1[63:4]};
        r_buf2      <= {4'h0, st_in2[63:4]};
        r_buf3      <= {4'h0, st_in3[63:4]};
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
        r_st_out1   <= '0;
        r_st_out2   <= '0;
        r_st_out3   <= '0;
      end else begin
        if (w_load_next) begin
          r_sb_in1    <= r_buf1[3:0];
          r_sb_in2    <= r_buf2[3:0];
          r_sb_in3    <= r_buf3[3:0];
          r_buf1      <= {4'h0, r_buf1[63:4]};
          r_buf2      <= {4'h0, r_buf2[63:4]};
          r_buf3      <= {4'h0, r_buf3[63:4]};
          r_issue_cnt <= r_issue_cnt + 4'd1;
        end else begin
          r_sb_in1 <= '0;
          r_sb_in2 <= '0;
          r_sb_in3 <= '0;
        end
        if (w_cap) begin
          r_st_out1[{r_cap_cnt, 2'b00} +: 4] <= sb_out1;
          r_st_out2[{r_cap_cnt, 2'b00} +: 4] <= sb_out2;
          r_st_out3[{r_cap_cnt, 2'b00} +: 4] <= sb_out3;
          r_cap_cnt <= r_cap_cnt + 4'd1;
        end
      end
    end
  end

  assign sb_in1  = r_sb_in1;
  assign sb_in2  = r_sb_in2;
  assign sb_in3  = r_sb_in3;
  assign rnd_en  = r_rnd_en;
  assign st_out1 = r_st_out1;
  assign st_out2 = r_st_out2;
  assign st_out3 = r_st_out3;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_led_sbox_serial_ctrl.sv
// Scoreboard bench: two DUTs (SBOX_LAT=1 and 3) share stimulus; a masked S-box model drives sb_out*.
module tb_led_sbox_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [63:0] st_in1, st_in2, st_in3;
  logic [3:0]  sbi1[2], sbi2[2], sbi3[2], sbo1[2], sbo2[2], sbo3[2];
  logic        rnd[2], busy[2], done[2];
  logic [63:0] so1[2], so2[2], so3[2];
  logic [11:0] dl[2][8];
  logic [3:0]  sbt[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LG = (g == 0) ? 1 : 3;
    led_sbox_serial_ctrl #(.SBOX_LAT(LG)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .st_in1(st_in1), .st_in2(st_in2), .st_in3(st_in3),
      .sb_in1(sbi1[g]), .sb_in2(sbi2[g]), .sb_in3(sbi3[g]),
      .rnd_en(rnd[g]),
      .sb_out1(sbo1[g]), .sb_out2(sbo2[g]), .sb_out3(sbo3[g]),
      .st_out1(so1[g]), .st_out2(so2[g]), .st_out3(so3[g]),
      .busy(busy[g]), .done(done[g])
    );
    assign sbo1[g] = dl[g][LG-1][11:8];
    assign sbo2[g] = dl[g][LG-1][7:4];
    assign sbo3[g] = dl[g][LG-1][3:0];
  end

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  // Scoreboard storage: stimulus writes wr/entries, monitor advances rd
  logic [63:0] exp_res[2][64];
  logic [63:0] exp_in[2][64];
  int          exp_S[2][64];
  int          wr[2], rd[2], next_ok[2];
  logic [63:0] last_exp[2];
  int          zero_req = 0, hold_req = 0, fin_req = 0;
  int          vectors = 0, miscompares = 0;

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbt[x[4*i +: 4]];
    return r;
  endfunction

  // Cycle number (relative to the start edge) in which done is high
  function automatic int plen(input int d);
    int lat;
    lat = (d == 0) ? 1 : 3;
`ifdef SBOX_PRECHARGE_EN
    return 31 + lat;
`else
    return 16 + lat;
`endif
  endfunction

  // Masked S-box pipeline model: (S(x1^x2^x3)^m1^m2, m1, m2), delayed by SBOX_LAT-1 registers
  initial begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) dl[d][k] = '0;
    forever begin
      logic [3:0] m1, m2, x;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 7; k > 0; k--) dl[d][k] = dl[d][k-1];
        m1 = 4'($urandom);
        m2 = 4'($urandom);
        x  = sbi1[d] ^ sbi2[d] ^ sbi3[d];
        dl[d][0] = {sbt[x] ^ m1 ^ m2, m1, m2};
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_inputs();
    st_in1 = {$urandom, $urandom};
    st_in2 = {$urandom, $urandom};
    st_in3 = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [63:0] a, b, c, input logic use_k, input logic [63:0] k);
    st_in1 = a;
    st_in2 = b;
    st_in3 = c;
    start  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (ec + 1 >= next_ok[d]) begin
        exp_res[d][wr[d]] = use_k ? k : sbox_layer(a ^ b ^ c);
        exp_in[d][wr[d]]  = a ^ b ^ c;
        exp_S[d][wr[d]]   = ec + 1;
        last_exp[d]       = exp_res[d][wr[d]];
        next_ok[d]        = ec + 1 + plen(d) + 1;
        wr[d]             = wr[d] + 1;
      end
    end
    step(1);
    start = 1'b0;
    rand_inputs();
  endtask

  task automatic issue_rand();
    issue({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, '0);
  endtask

  task automatic wait_idle();
    while (ec + 1 < next_ok[0] || ec + 1 < next_ok[1]) step(1);
    step(1);
  endtask

  // Monitor / checker
  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, expv);
    end
  endtask

  initial begin
    int          zero_seen = 0, hold_seen = 0, fin_seen = 0;
    int          rcnt[2];
    logic [63:0] issued[2];
    logic        bad[2], prev_rnd[2], pend;
    logic [63:0] rec;
    for (int d = 0; d < 2; d++) begin
      rcnt[d] = 0; issued[d] = '0; bad[d] = 1'b0; prev_rnd[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (zero_req != zero_seen) begin
        zero_seen = zero_req;
        for (int d = 0; d < 2; d++) begin
          chk("reset_busy", d, 64'(busy[d]), '0);
          chk("reset_done", d, 64'(done[d]), '0);
          chk("reset_rnd_en", d, 64'(rnd[d]), '0);
          chk("reset_sb_in", d, 64'({sbi1[d], sbi2[d], sbi3[d]}), '0);
          chk("reset_st_out1", d, so1[d], '0);
          chk("reset_st_out2", d, so2[d], '0);
          chk("reset_st_out3", d, so3[d], '0);
        end
      end
      if (hold_req != hold_seen) begin
        hold_seen = hold_req;
        for (int d = 0; d < 2; d++) begin
          chk("held_result", d, so1[d] ^ so2[d] ^ so3[d], last_exp[d]);
          chk("idle_busy", d, 64'(busy[d]), '0);
        end
      end
      if (fin_req != fin_seen) begin
        fin_seen = fin_req;
        for (int d = 0; d < 2; d++) begin
          chk("all_passes_done", d, 64'(rd[d]), 64'(wr[d]));
          chk("idle_protocol", d, 64'(bad[d]), '0);
        end
      end
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          rd[d] = wr[d]; rcnt[d] = 0; issued[d] = '0; bad[d] = 1'b0; prev_rnd[d] = 1'b0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (rnd[d]) begin
            rcnt[d]   = rcnt[d] + 1;
            issued[d] = {sbi1[d] ^ sbi2[d] ^ sbi3[d], issued[d][63:4]};
`ifdef SBOX_PRECHARGE_EN
            if (prev_rnd[d]) bad[d] = 1'b1;
`endif
          end else if ({sbi1[d], sbi2[d], sbi3[d]} != 12'h0) begin
            bad[d] = 1'b1;
          end
          prev_rnd[d] = rnd[d];
          pend = (rd[d] != wr[d]) && (ec >= exp_S[d][rd[d]]);
          if (busy[d] != pend) bad[d] = 1'b1;
          if (done[d]) begin
            if (rd[d] == wr[d]) begin
              chk("unexpected_done", d, 64'(done[d]), '0);
            end else begin
              rec = so1[d] ^ so2[d] ^ so3[d];
              chk("done_cycle", d, 64'(ec - exp_S[d][rd[d]] + 1), 64'(plen(d)));
              chk("result", d, rec, exp_res[d][rd[d]]);
              chk("issue_order", d, issued[d], exp_in[d][rd[d]]);
              chk("rnd_en_count", d, 64'(rcnt[d]), 64'd16);
              chk("slot_protocol", d, 64'(bad[d]), '0);
              chk("shares_not_recombined", d,
                  64'((so1[d] == rec) || (so2[d] == rec) || (so3[d] == rec)), '0);
              rd[d] = rd[d] + 1;
            end
            rcnt[d] = 0; issued[d] = '0; bad[d] = 1'b0;
          end else if (rd[d] != wr[d] && ec > exp_S[d][rd[d]] + plen(d) - 1) begin
            chk("done_timeout", d, 64'(done[d]), 64'd1);
            rd[d] = rd[d] + 1;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [63:0] a, b;
    for (int d = 0; d < 2; d++) begin
      wr[d] = 0; rd[d] = 0; next_ok[d] = 0; last_exp[d] = '0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    st_in1 = '0; st_in2 = '0; st_in3 = '0;
    step(3);
    zero_req++;
    step(1);
    rst_n = 1'b1;
    step(1);

    issue('0, '0, '0, 1'b1, 64'hCCCC_CCCC_CCCC_CCCC);
    wait_idle();

    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    issue(a, b, 64'hFEDC_BA98_7654_3210 ^ a ^ b, 1'b1, 64'h2174_8FE3_DA09_B65C);
    wait_idle();
    hold_req++;
    step(2);

    // Starts in cycles 5 and 17 of a pass, then cycle 18
    issue_rand();
    step(4);
    issue_rand();
    step(11);
    issue_rand();
    issue_rand();
    wait_idle();
    hold_req++;
    step(1);

    // Reset asserted during cycle 8 of a pass
    issue_rand();
    step(7);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      next_ok[d]  = ec + 2;
      last_exp[d] = '0;
    end
    step(1);
    rst_n = 1'b1;
    zero_req++;
    step(1);
    hold_req++;
    step(1);
    issue_rand();
    wait_idle();
    hold_req++;
    step(1);

    repeat (300) begin
      if ($urandom_range(0, 5) == 0 && wr[0] < 56 && wr[1] < 56) issue_rand();
      else begin
        step(1);
        rand_inputs();
      end
    end
    wait_idle();
    hold_req++;
    step(1);
    fin_req++;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
